// File: rtl/mem_request_queue.sv
// In-order request FIFO between the trace parser and the DDR5 command scheduler.
// Decodes each request address on write and releases the head once sim_time reaches its arrival cycle.
module mem_request_queue #(
  parameter int DEPTH          = 16,
  parameter int MEM_ADDR_WIDTH = 34,
  parameter int CPU_CORE_WIDTH = 4,
  parameter int MEM_OPN_WIDTH  = 3,
  parameter int TIME_WIDTH     = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [TIME_WIDTH-1:0]     in_time,
  input  logic [CPU_CORE_WIDTH-1:0] in_core,
  input  logic [MEM_OPN_WIDTH-1:0]  in_opn,
  input  logic [MEM_ADDR_WIDTH-1:0] in_addr,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CPU_CORE_WIDTH-1:0] out_core,
  output logic [MEM_OPN_WIDTH-1:0]  out_opn,
  output logic [15:0]               out_row,
  output logic [9:0]                out_column,
  output logic [1:0]                out_bank,
  output logic [2:0]                out_bank_group,
  output logic                      out_channel,
  output logic [1:0]                out_byte_sel,
  output logic [TIME_WIDTH-1:0]     out_time,
  output logic [TIME_WIDTH-1:0]     sim_time,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      full,
  output logic                      empty,
  output logic                      opn_err,
  output logic                      order_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [TIME_WIDTH-1:0]     t;
    logic [CPU_CORE_WIDTH-1:0] core;
    logic [MEM_OPN_WIDTH-1:0]  opn;
    logic [15:0]               row;
    logic [9:0]                column;
    logic [1:0]                bank;
    logic [2:0]                bank_group;
    logic                      channel;
    logic [1:0]                byte_sel;
  } entry_t;

  entry_t                mem [DEPTH];
  entry_t                new_entry;
  entry_t                head;
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         count_next;
  logic [TIME_WIDTH-1:0] last_time;
  logic                  push_hs;
  logic                  legal;
  logic                  wr;
  logic                  pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign in_ready = !full;
  assign push_hs  = in_valid && in_ready;
  assign legal    = (in_opn <= MEM_OPN_WIDTH'(2));
  assign wr       = push_hs && legal;

  always_comb begin
    new_entry            = '0;
    new_entry.t          = in_time;
    new_entry.core       = in_core;
    new_entry.opn        = in_opn;
    new_entry.row        = in_addr[33:18];
    new_entry.column     = {in_addr[17:12], in_addr[5:2]};
    new_entry.bank       = in_addr[11:10];
    new_entry.bank_group = in_addr[9:7];
    new_entry.channel    = in_addr[6];
    new_entry.byte_sel   = in_addr[1:0];
  end

  // Head fields are forced to zero while empty so stale storage never shows after reset.
  always_comb begin
    head = '0;
    if (!empty) head = mem[rd_ptr];
  end

  assign out_valid      = !empty && (head.t <= sim_time);
  assign pop            = out_valid && out_ready;
  assign out_core       = head.core;
  assign out_opn        = head.opn;
  assign out_row        = head.row;
  assign out_column     = head.column;
  assign out_bank       = head.bank;
  assign out_bank_group = head.bank_group;
  assign out_channel    = head.channel;
  assign out_byte_sel   = head.byte_sel;
  assign out_time       = head.t;

  always_comb begin
    count_next = count;
    case ({wr, pop})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst && wr) mem[wr_ptr] <= new_entry;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      sim_time  <= '0;
      last_time <= '0;
      opn_err   <= 1'b0;
      order_err <= 1'b0;
    end else begin
      sim_time  <= sim_time + TIME_WIDTH'(1);
      count     <= count_next;
      opn_err   <= push_hs && !legal;
      order_err <= wr && (in_time < last_time);
      if (wr) begin
        wr_ptr    <= wr_ptr + PW'(1);
        last_time <= in_time;
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
    end
  end

endmodule

// File: tb/tb_mem_request_queue.sv
// Directed bench for mem_request_queue: a cycle table for release timing and
// opcode errors, then hand sequences for ordering, full, wrap and mid-run reset.
module tb_mem_request_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_time;
  logic [3:0]  in_core;
  logic [2:0]  in_opn;
  logic [33:0] in_addr;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_core;
  logic [2:0]  out_opn;
  logic [15:0] out_row;
  logic [9:0]  out_column;
  logic [1:0]  out_bank;
  logic [2:0]  out_bank_group;
  logic        out_channel;
  logic [1:0]  out_byte_sel;
  logic [63:0] out_time;
  logic [63:0] sim_time;
  logic [4:0]  count;
  logic        full;
  logic        empty;
  logic        opn_err;
  logic        order_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_request_queue #(
    .DEPTH(16), .MEM_ADDR_WIDTH(34), .CPU_CORE_WIDTH(4), .MEM_OPN_WIDTH(3), .TIME_WIDTH(64)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_time(in_time), .in_core(in_core),
    .in_opn(in_opn), .in_addr(in_addr),
    .out_valid(out_valid), .out_ready(out_ready), .out_core(out_core), .out_opn(out_opn),
    .out_row(out_row), .out_column(out_column), .out_bank(out_bank),
    .out_bank_group(out_bank_group), .out_channel(out_channel), .out_byte_sel(out_byte_sel),
    .out_time(out_time), .sim_time(sim_time), .count(count), .full(full), .empty(empty),
    .opn_err(opn_err), .order_err(order_err)
  );

  typedef struct {
    logic        rst, iv;
    logic [63:0] t;
    logic [3:0]  core;
    logic [2:0]  opn;
    logic [33:0] addr;
    logic        ordy;
    logic [63:0] e_sim;
    int          e_cnt;
    logic        e_ov, e_ir, e_oe, e_ore;
    logic [3:0]  e_core;
    logic [2:0]  e_opn;
    logic [33:0] e_addr;
    logic [63:0] e_time;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic iv, logic [63:0] t, logic [3:0] core, logic [2:0] opn,
                              logic [33:0] addr, logic ordy, logic [63:0] e_sim, int e_cnt,
                              logic e_ov, logic e_ir, logic e_oe, logic e_ore, logic [3:0] e_core,
                              logic [2:0] e_opn, logic [33:0] e_addr, logic [63:0] e_time);
    vec_t v;
    v.rst = r; v.iv = iv; v.t = t; v.core = core; v.opn = opn; v.addr = addr; v.ordy = ordy;
    v.e_sim = e_sim; v.e_cnt = e_cnt; v.e_ov = e_ov; v.e_ir = e_ir; v.e_oe = e_oe; v.e_ore = e_ore;
    v.e_core = e_core; v.e_opn = e_opn; v.e_addr = e_addr; v.e_time = e_time;
    return v;
  endfunction

  // Expected {row, column, bank, bank_group, channel, byte_sel} for a byte address.
  function automatic logic [33:0] dec(logic [33:0] a);
    return {a[33:18], a[17:12], a[5:2], a[11:10], a[9:7], a[6], a[1:0]};
  endfunction

  function automatic logic [33:0] addr_of(int i);
    logic [15:0] r;
    logic [17:0] lo;
    r  = 16'(i * 257 + 1);
    lo = 18'(i * 723 + 7);
    return {r, lo};
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (sim_time=%0d)", nm, act, exp, sim_time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic iv, logic [63:0] t, logic [3:0] core, logic [2:0] opn, logic [33:0] a);
    in_valid = iv; in_time = t; in_core = core; in_opn = opn; in_addr = a;
  endtask

  task automatic chk_head(string nm, logic [3:0] core, logic [33:0] a);
    chk({nm, "_valid"}, 64'(out_valid), 64'd1);
    chk({nm, "_core"}, 64'(out_core), 64'(core));
    chk({nm, "_fields"},
        64'({out_row, out_column, out_bank, out_bank_group, out_channel, out_byte_sel}),
        64'(dec(a)));
  endtask

  initial begin : main
    bit found;
    rst = 1'b1; out_ready = 1'b0;
    drive(1'b0, '0, '0, '0, '0);

    // Cycle number equals sim_time after the reset row.
    vecs.push_back(mk(1,0,0,0,0,0,0,               0,0,0,1,0,0, 0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,               0,0,0,1,0,0, 0,0,0,0));
    vecs.push_back(mk(0,1,5,3,0,34'h3_FFFF_FFFF,0, 1,0,0,1,0,0, 0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,               2,1,0,1,0,0, 0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,               3,1,0,1,0,0, 0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,               4,1,0,1,0,0, 0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,1,               5,1,1,1,0,0, 3,0,34'h3_FFFF_FFFF,5));
    vecs.push_back(mk(0,0,0,0,0,0,0,               6,0,0,1,0,0, 0,0,0,0));
    vecs.push_back(mk(0,1,0,1,5,34'h123,0,         7,0,0,1,0,0, 0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,               8,0,0,1,1,0, 0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,               9,0,0,1,0,0, 0,0,0,0));
    vecs.push_back(mk(0,1,9,6,3,34'h55,0,          10,0,0,1,0,0, 0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,               11,0,0,1,1,0, 0,0,0,0));
    vecs.push_back(mk(0,1,12,7,2,34'h2_8C3A_5E6D,1, 12,0,0,1,0,0, 0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,1,               13,1,1,1,0,0, 7,2,34'h2_8C3A_5E6D,12));
    vecs.push_back(mk(0,0,0,0,0,0,0,               14,0,0,1,0,0, 0,0,0,0));

    foreach (vecs[i]) begin
      rst = vecs[i].rst;
      out_ready = vecs[i].ordy;
      drive(vecs[i].iv, vecs[i].t, vecs[i].core, vecs[i].opn, vecs[i].addr);
      if (!vecs[i].rst) begin
        chk("tbl_sim_time", sim_time, vecs[i].e_sim);
        chk("tbl_count", 64'(count), 64'(vecs[i].e_cnt));
        chk("tbl_empty", 64'(empty), 64'(vecs[i].e_cnt == 0));
        chk("tbl_full", 64'(full), 64'(vecs[i].e_cnt == 16));
        chk("tbl_out_valid", 64'(out_valid), 64'(vecs[i].e_ov));
        chk("tbl_in_ready", 64'(in_ready), 64'(vecs[i].e_ir));
        chk("tbl_opn_err", 64'(opn_err), 64'(vecs[i].e_oe));
        chk("tbl_order_err", 64'(order_err), 64'(vecs[i].e_ore));
        if (vecs[i].e_ov) begin
          chk_head("tbl_head", vecs[i].e_core, vecs[i].e_addr);
          chk("tbl_opn", 64'(out_opn), 64'(vecs[i].e_opn));
          chk("tbl_time", out_time, vecs[i].e_time);
        end
      end
      step();
    end
    rst = 1'b0; out_ready = 1'b0;

    // Out-of-order arrival times: flagged, kept, released in push order.
    drive(1'b1, 64'd100, 4'd2, 3'd1, 34'h1_2345_6789);
    step();
    drive(1'b1, 64'd50, 4'd4, 3'd0, 34'h0_9876_5432);
    chk("ord_no_err_first", 64'(order_err), 64'd0);
    step();
    drive(1'b0, '0, '0, '0, '0);
    chk("ord_err_pulse", 64'(order_err), 64'd1);
    chk("ord_count", 64'(count), 64'd2);
    step();
    chk("ord_err_clear", 64'(order_err), 64'd0);
    found = 1'b0;
    for (int n = 0; n < 200; n++) begin
      if (out_valid) begin found = 1'b1; break; end
      step();
    end
    chk("ord_release_found", 64'(found), 64'd1);
    chk("ord_release_time", sim_time, 64'd100);
    chk_head("ord_head0", 4'd2, 34'h1_2345_6789);
    out_ready = 1'b1;
    step();
    chk_head("ord_head1", 4'd4, 34'h0_9876_5432);
    chk("ord_head1_time", out_time, 64'd50);
    step();
    out_ready = 1'b0;
    chk("ord_drained", 64'(empty), 64'd1);

    // Fill to DEPTH, then a pop cycle that must refuse the concurrent push.
    rst = 1'b1; step(); rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 64'd0, 4'(i), 3'(i % 3), addr_of(i));
      chk("full_fill_ready", 64'(in_ready), 64'd1);
      chk("full_fill_order_err", 64'(order_err), 64'd0);
      step();
    end
    drive(1'b1, 64'd0, 4'(16), 3'(16 % 3), addr_of(16));
    chk("full_count", 64'(count), 64'd16);
    chk("full_flag", 64'(full), 64'd1);
    chk("full_in_ready", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    chk_head("full_head0", 4'd0, addr_of(0));
    step();
    chk("full_refused_count", 64'(count), 64'd15);
    chk("full_ready_again", 64'(in_ready), 64'd1);
    for (int j = 1; j <= 16; j++) begin
      chk_head("full_drain", 4'(j), addr_of(j));
      step();
      drive(1'b0, '0, '0, '0, '0);
      if (j == 1) chk("full_pushpop_count", 64'(count), 64'd15);
    end
    out_ready = 1'b0;
    chk("full_empty", 64'(empty), 64'd1);

    // Steady push+pop at occupancy 4 across 40 requests (pointers wrap twice).
    rst = 1'b1; step(); rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 64'd0, 4'(k), 3'(k % 3), addr_of(k));
      step();
    end
    out_ready = 1'b1;
    for (int k = 4; k < 40; k++) begin
      drive(1'b1, 64'd0, 4'(k), 3'(k % 3), addr_of(k));
      chk("stream_count", 64'(count), 64'd4);
      chk_head("stream_head", 4'(k - 4), addr_of(k - 4));
      step();
    end
    drive(1'b0, '0, '0, '0, '0);
    for (int j = 36; j < 40; j++) begin
      chk_head("stream_tail", 4'(j), addr_of(j));
      step();
    end
    out_ready = 1'b0;
    chk("stream_empty", 64'(empty), 64'd1);

    // Reset with pending, released entries discards everything.
    for (int k = 0; k < 7; k++) begin
      drive(1'b1, 64'd0, 4'(k), 3'd0, addr_of(k));
      step();
    end
    drive(1'b0, '0, '0, '0, '0);
    chk("rst_pending_count", 64'(count), 64'd7);
    chk("rst_pending_valid", 64'(out_valid), 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_sim_time", sim_time, 64'd0);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_time", out_time, 64'd0);
    drive(1'b1, 64'd2, 4'd9, 3'd1, 34'h0_0000_00C5);
    step();
    drive(1'b0, '0, '0, '0, '0);
    found = 1'b0;
    for (int n = 0; n < 10; n++) begin
      if (out_valid) begin found = 1'b1; break; end
      step();
    end
    chk("rst_release_found", 64'(found), 64'd1);
    chk("rst_release_time", sim_time, 64'd2);
    chk_head("rst_head", 4'd9, 34'h0_0000_00C5);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("rst_final_empty", 64'(empty), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
